// File: rtl/mdu_alu_sequencer.sv
// Iterative unsigned MULTU/DIVU sequencer. It borrows the execute-stage ALU for DATA_W
// cycles per operation and accumulates the 64-bit HI/LO result.
module mdu_alu_sequencer #(
    parameter int          DATA_W   = 32,
    parameter logic [3:0]  SEL_ADD  = 4'b0010,
    parameter logic [3:0]  SEL_SUB  = 4'b0110,
    parameter logic [3:0]  SEL_IDLE = 4'b0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] alu_src_A,
    output logic [DATA_W-1:0] alu_src_B,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result
);

    localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic              OP_MULTU = 1'b0;
    localparam logic              OP_DIVU  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic              op_r;
    logic [DATA_W-1:0] operand_b_r;   // multiplicand or divisor, frozen at acceptance

    logic [DATA_W-1:0] div_shift;
    logic              mul_carry;
    logic              div_ge;

    // Restoring divide: the partial remainder shifted left by one, pulling in the next dividend bit.
    assign div_shift = {hi[DATA_W-2:0], lo[DATA_W-1]};
    assign mul_carry = (alu_result < hi);
    assign div_ge    = hi[DATA_W-1] | (div_shift >= operand_b_r);

    // NOTE: every output written here gets a default first, so no latch can be inferred.
    always_comb begin
        alu_src_A = '0;
        alu_src_B = '0;
        alu_sel   = SEL_IDLE;
        if (state == S_RUN) begin
            if (op_r == OP_DIVU) begin
                alu_src_A = div_shift;
                alu_src_B = operand_b_r;
                alu_sel   = SEL_SUB;
            end else begin
                alu_src_A = hi;
                alu_src_B = lo[0] ? operand_b_r : '0;
                alu_sel   = SEL_ADD;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, and the async reset clears
    // every register, including the result registers, so a mid-operation reset leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            count       <= '0;
            op_r        <= OP_MULTU;
            operand_b_r <= '0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r        <= op;
                        operand_b_r <= operand_b;
                        count       <= '0;
                        if (op == OP_DIVU && operand_b == '0) begin
                            hi          <= operand_a;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            hi          <= '0;
                            lo          <= operand_a;
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                            state       <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    if (op_r == OP_DIVU) begin
                        hi <= div_ge ? alu_result : div_shift;
                        lo <= {lo[DATA_W-2:0], div_ge};
                    end else begin
                        // The carry out of the add becomes the new top bit of the product.
                        hi <= {mul_carry, alu_result[DATA_W-1:1]};
                        lo <= {alu_result[0], lo[DATA_W-1:1]};
                    end
                    if (count == LAST_CNT) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_alu_sequencer.sv
// Self-checking bench for mdu_alu_sequencer: an arithmetic reference model plus a per-cycle
// monitor of the ALU handshake, busy length and result validity.
module tb_mdu_alu_sequencer;

    localparam int         W        = 32;
    localparam logic [3:0] SEL_ADD  = 4'b0010;
    localparam logic [3:0] SEL_SUB  = 4'b0110;
    localparam logic [3:0] SEL_IDLE = 4'b0000;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          op;
    logic [W-1:0]  operand_a;
    logic [W-1:0]  operand_b;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [W-1:0]  alu_src_A;
    logic [W-1:0]  alu_src_B;
    logic [3:0]    alu_sel;
    logic [W-1:0]  alu_result;

    int errors = 0;
    int checks = 0;

    logic          m_op;
    logic [64:0]   m_exp;      // {div_by_zero, hi, lo} the current operation must produce
    bit            aborted = 0;
    int            run_len = 0;

    mdu_alu_sequencer #(
        .DATA_W(W), .SEL_ADD(SEL_ADD), .SEL_SUB(SEL_SUB), .SEL_IDLE(SEL_IDLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo),
        .alu_src_A(alu_src_A), .alu_src_B(alu_src_B), .alu_sel(alu_sel),
        .alu_result(alu_result)
    );

    // Behavioural datapath ALU shared with the execute stage.
    assign alu_result = (alu_sel == SEL_ADD) ? alu_src_A + alu_src_B :
                        (alu_sel == SEL_SUB) ? alu_src_A - alu_src_B : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [64:0] model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] prod;
        if (!o) begin
            prod = 64'(a) * 64'(b);
            return {1'b0, prod};
        end
        if (b == '0)
            return {1'b1, a, {W{1'b1}}};
        return {1'b0, a % b, a / b};
    endfunction

    // Per-cycle monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (busy) begin
            run_len++;
            check("alu_sel_run", 64'(alu_sel), 64'(m_op ? SEL_SUB : SEL_ADD));
            check("busy_done_excl", 64'(done), 64'd0);
        end else begin
            check("alu_sel_idle", 64'(alu_sel), 64'(SEL_IDLE));
            check("alu_src_idle", {alu_src_A, alu_src_B}, 64'd0);
            if (run_len != 0) begin
                if (!aborted)
                    check("busy_len", 64'(run_len), 64'(W));
                run_len = 0;
                aborted = 0;
            end
        end
        if (done)
            check("done_result", {31'd0, div_by_zero, hi, lo}, {31'd0, m_exp});
    end

    task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inject_at, input int reset_at);
        int lat;
        bit seen;
        int exp_lat;
        m_op    = o;
        m_exp   = model(o, a, b);
        exp_lat = (o && b == '0) ? 2 : W + 2;
        @(posedge clk); #1;
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        lat  = 1;
        seen = 0;
        while (!seen && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            if (lat == 2) begin
                operand_a = $urandom;
                operand_b = $urandom;
                op        = ~o;
            end
            if (lat == inject_at) begin
                start     = 1'b1;
                operand_a = 32'h0000_1234;
                operand_b = 32'h0000_0005;
                check("inject_busy", 64'(busy), 64'd1);
            end
            if (lat == reset_at) begin
                aborted = 1;
                rst_n   = 1'b0;
                #1;
                check("rst_clear", {30'd0, busy, done, hi, lo}, 64'd0);
                check("rst_dbz", 64'(div_by_zero), 64'd0);
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk); #1;
                    check("rst_no_done", {62'd0, busy, done}, 64'd0);
                end
                rst_n = 1'b1;
                return;
            end
            if (done) seen = 1;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("result", {31'd0, div_by_zero, hi, lo}, {31'd0, m_exp});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        check("hold_idle", {31'd0, div_by_zero, hi, lo}, {31'd0, m_exp});
        check("idle_flags", {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        op        = 1'b0;
        operand_a = '0;
        operand_b = '0;
        m_op      = 1'b0;
        m_exp     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {29'd0, busy, done, div_by_zero, hi, lo}, 64'd0);
        rst_n = 1'b1;

        // Hand-computed values pin the reference model.
        check("pin_mul_7x6", model(1'b0, 32'd7, 32'd6), 65'd42);
        check("pin_mul_max", model(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), {1'b0, 64'hFFFF_FFFE_0000_0001});
        check("pin_div_100_7", model(1'b1, 32'd100, 32'd7), {1'b0, 32'd2, 32'd14});
        check("pin_div_big", model(1'b1, 32'h8000_0000, 32'd3), {1'b0, 32'd2, 32'h2AAA_AAAA});
        check("pin_div_zero", model(1'b1, 32'd5, 32'd0), {1'b1, 32'd5, 32'hFFFF_FFFF});

        run_op(1'b0, 32'd7, 32'd6, 0, 0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(1'b1, 32'd100, 32'd7, 0, 0);
        run_op(1'b1, 32'h8000_0000, 32'd3, 0, 0);
        run_op(1'b1, 32'd5, 32'd0, 0, 0);
        run_op(1'b1, 32'd1000, 32'd10, 0, 0);           // clears the held div_by_zero
        run_op(1'b0, 32'h0001_2345, 32'h0000_ABCD, 12, 0);
        run_op(1'b1, 32'hDEAD_BEEF, 32'h0000_0123, 0, 17);
        run_op(1'b1, 32'hDEAD_BEEF, 32'h0000_0123, 0, 0);
        run_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 0, 0);
        run_op(1'b0, 32'h8000_0000, 32'd2, 0, 0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
